// File: rtl/vector_pkg.sv
// Shared definitions for the vector issue units: ALU opcodes, sequencer
// FSM encoding and default sizing.
package vector_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned VLMAX_DEF  = 32;
    localparam int unsigned VL_W_DEF   = 6;
    localparam int unsigned SEL_W      = 3;

    localparam logic [SEL_W-1:0] VOP_ADD   = 3'd0;
    localparam logic [SEL_W-1:0] VOP_SUB   = 3'd1;
    localparam logic [SEL_W-1:0] VOP_MUL   = 3'd2;
    localparam logic [SEL_W-1:0] VOP_CONST = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } vseq_state_e;

endpackage

// File: rtl/vector_alu_sequencer_if.sv
// Bus bundle between the vector ALU sequencer and its environment:
// command, operand stream, external ALU port, result stream and done.
//   master : command issuer / operand source / ALU model / result consumer
//   slave  : the sequencer
// With VSEQ_MASK_EN defined the operand stream carries a per-element src_mask.
interface vector_alu_sequencer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned VL_W   = 6
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_sel;
    logic [VL_W-1:0]   cmd_vl;
    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
`ifdef VSEQ_MASK_EN
    logic              src_mask;
`endif
    logic              alu_ena;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_sel;
    logic [DATA_W-1:0] alu_result;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_last;
    logic              done;

    modport master (
        output cmd_valid, cmd_sel, cmd_vl,
        input  cmd_ready,
`ifdef VSEQ_MASK_EN
        output src_mask,
`endif
        output src_valid, src_a, src_b,
        input  src_ready,
        input  alu_ena, alu_a, alu_b, alu_sel,
        output alu_result,
        input  res_valid, res_data, res_last, done,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_vl,
        output cmd_ready,
`ifdef VSEQ_MASK_EN
        input  src_mask,
`endif
        input  src_valid, src_a, src_b,
        output src_ready,
        output alu_ena, alu_a, alu_b, alu_sel,
        input  alu_result,
        output res_valid, res_data, res_last, done,
        input  res_ready
    );
endinterface

// File: rtl/vseq_out_reg.sv
// One-entry valid/ready output register holding data plus a last flag.
// Ports: clk, rst_n; load_i/data_i/last_i write side (caller loads only
// when in_ready_c); ready_i consumer ready; valid_o/data_o/last_o
// registered outputs; in_ready_c combinational "can load this cycle".
// A pop and a load in the same cycle reload without a bubble.
module vseq_out_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              in_ready_c
);
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    assign in_ready_c = !valid_q || ready_i;

    // Load wins over pop; data/last only change on load so they hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
endmodule

// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: accepts one command (opcode, length), streams
// operand pairs into the external combinational ALU one element per cycle,
// captures each result into a valid/ready result stream, flags the last
// element and pulses done when the command retires.
// Ports: clk, rst_n (async, active low); bus (vector_alu_sequencer_if.slave)
// carrying cmd_*, src_*, alu_*, res_* and done.
// Build option VSEQ_MASK_EN: adds src_mask; masked-off elements bypass the
// ALU (alu_ena=0) and pass src_a through unchanged.
module vector_alu_sequencer
    import vector_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned VLMAX  = VLMAX_DEF,
    parameter int unsigned VL_W   = VL_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vector_alu_sequencer_if.slave   bus
);
    localparam logic [VL_W-1:0] VLMAX_V = VL_W'(VLMAX);

    vseq_state_e       state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [VL_W-1:0]   vl_q, vl_d;
    logic [VL_W-1:0]   idx_q, idx_d;
    logic              cmd_ready_q;
    logic              done_q;

    logic              out_ready_c;
    logic              fire_c;
    logic              is_last_c;
    logic              active_c;
    logic [VL_W-1:0]   vl_clamp_c;
    logic [DATA_W-1:0] res_in_c;

    assign vl_clamp_c = (bus.cmd_vl > VLMAX_V) ? VLMAX_V : bus.cmd_vl;
    assign fire_c     = (state_q == ST_RUN) && bus.src_valid && out_ready_c;
    assign is_last_c  = (idx_q == (vl_q - VL_W'(1)));

`ifdef VSEQ_MASK_EN
    assign active_c = bus.src_mask;
`else
    assign active_c = 1'b1;
`endif

    // Inactive elements keep src_a instead of the ALU result.
    assign res_in_c = active_c ? bus.alu_result : bus.src_a;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vl_d    = vl_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    sel_d   = bus.cmd_sel;
                    vl_d    = vl_clamp_c;
                    idx_d   = '0;
                    state_d = (vl_clamp_c == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (fire_c) begin
                    idx_d = idx_q + VL_W'(1);
                    if (is_last_c) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.res_valid && bus.res_ready && bus.res_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; cmd_ready and done are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            vl_q        <= '0;
            idx_q       <= '0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            vl_q        <= vl_d;
            idx_q       <= idx_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    vseq_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (fire_c),
        .data_i     (res_in_c),
        .last_i     (is_last_c),
        .ready_i    (bus.res_ready),
        .valid_o    (bus.res_valid),
        .data_o     (bus.res_data),
        .last_o     (bus.res_last),
        .in_ready_c (out_ready_c)
    );

    // The ALU operands must be driven in the same cycle as the fire.
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.done      = done_q;
    assign bus.src_ready = (state_q == ST_RUN) && out_ready_c;
    assign bus.alu_ena   = fire_c && active_c;
    assign bus.alu_a     = fire_c ? bus.src_a : '0;
    assign bus.alu_b     = fire_c ? bus.src_b : '0;
    assign bus.alu_sel   = sel_q;
endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Bench for vector_alu_sequencer: directed commands plus random commands
// checked against an element-level reference (expected result list, result
// occupancy, done timing) kept in the bench.
module tb_vector_alu_sequencer;
    import vector_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned VW  = 6;
    localparam int          VLM = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vector_alu_sequencer_if #(.DATA_W(DW), .VL_W(VW)) bus ();

    vector_alu_sequencer #(.DATA_W(DW), .VLMAX(VLM), .VL_W(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] op_a [64];
    logic [31:0] op_b [64];
    logic        op_m [64];

    function automatic logic [31:0] alu_fn(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return 32'd254;
            default: return 32'd0;
        endcase
    endfunction

    // External ALU stand-in; garbage when disabled so stray captures show up.
    always_comb bus.alu_result = bus.alu_ena ? alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
        chk({tag, "_src_ready"}, 64'(bus.src_ready), 64'd0);
        chk({tag, "_alu_ena"},   64'(bus.alu_ena),   64'd0);
        chk({tag, "_alu_ab"},    {bus.alu_a, bus.alu_b}, 64'd0);
        chk({tag, "_alu_sel"},   64'(bus.alu_sel),   64'd0);
        chk({tag, "_res"},       {bus.res_data, 30'd0, bus.res_valid, bus.res_last}, 64'd0);
        chk({tag, "_done"},      64'(bus.done),      64'd0);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
            op_m[i] = 1'b1;
        end
    endtask

    // rmode: 0 res_ready high, 1 random, 2 low for 3 cycles from the first result.
    // vmode: 0 src_valid always high, 1 random gaps. abort_after >= 0 returns after that many fires.
    task automatic run_cmd(input logic [2:0] sel, input int vl, input int rmode, input int vmode, input int abort_after);
        int          vle;
        logic [31:0] expq [$];
        int          fed, fired, popped, cyc, bp_cnt, w;
        logic        pend_done, seen_done, hold, hold_l, fire, pop, exp_sr, act;
        logic [31:0] hold_d;
        string       pfx;
        pfx = $sformatf("sel%0d_vl%0d", sel, vl);
        vle = (vl > VLM) ? VLM : vl;
        for (int i = 0; i < vle; i++) begin
`ifdef VSEQ_MASK_EN
            expq.push_back(op_m[i] ? alu_fn(sel, op_a[i], op_b[i]) : op_a[i]);
`else
            expq.push_back(alu_fn(sel, op_a[i], op_b[i]));
`endif
        end

        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_sel   = sel;
        bus.cmd_vl    = VW'(vl);
        #1;
        chk({pfx, "_cmd_ready_idle"}, 64'(bus.cmd_ready), 64'd1);
        w = 0;
        while (!bus.cmd_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!bus.cmd_ready) begin
            chk({pfx, "_cmd_accept_timeout"}, 64'(bus.cmd_ready), 64'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);

        fed = 0; fired = 0; popped = 0; cyc = 0; bp_cnt = -1;
        pend_done = (vle == 0); seen_done = 1'b0; hold = 1'b0; hold_d = '0; hold_l = 1'b0;
        while (!seen_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.cmd_valid = 1'b0;
            if (abort_after >= 0 && fed == abort_after) return;
            case (rmode)
                0: bus.res_ready = 1'b1;
                1: bus.res_ready = ($urandom % 3) != 0;
                default: begin
                    if (bp_cnt < 0 && bus.res_valid) bp_cnt = 3;
                    if (bp_cnt > 0) begin
                        bus.res_ready = 1'b0;
                        bp_cnt--;
                    end else begin
                        bus.res_ready = 1'b1;
                    end
                end
            endcase
            if (fed < vle) begin
                bus.src_valid = (vmode == 0) ? 1'b1 : (($urandom % 4) != 0);
                bus.src_a     = op_a[fed];
                bus.src_b     = op_b[fed];
`ifdef VSEQ_MASK_EN
                bus.src_mask  = op_m[fed];
`endif
            end else begin
                bus.src_valid = 1'b0;
                bus.src_a     = $urandom;
                bus.src_b     = $urandom;
            end
            #1;
            chk({pfx, "_done"}, 64'(bus.done), 64'(pend_done));
            if (pend_done) seen_done = 1'b1;
            pend_done = 1'b0;
            chk({pfx, "_cmd_ready_busy"}, 64'(bus.cmd_ready), 64'd0);
            chk({pfx, "_res_valid"}, 64'(bus.res_valid), 64'((fired - popped) > 0));
            if (hold && bus.res_valid) begin
                chk({pfx, "_hold"}, {31'd0, bus.res_last, bus.res_data}, {31'd0, hold_l, hold_d});
            end
            exp_sr = (fed < vle) ? (!bus.res_valid || bus.res_ready) : 1'b0;
            chk({pfx, "_src_ready"}, 64'(bus.src_ready), 64'(exp_sr));
            fire = bus.src_valid && bus.src_ready;
            if (fire) begin
`ifdef VSEQ_MASK_EN
                act = op_m[fed];
`else
                act = 1'b1;
`endif
                chk({pfx, "_alu_ena"}, 64'(bus.alu_ena), 64'(act));
                chk({pfx, "_alu_ab"}, {bus.alu_a, bus.alu_b}, {op_a[fed], op_b[fed]});
                chk({pfx, "_alu_sel"}, 64'(bus.alu_sel), 64'(sel));
            end else begin
                chk({pfx, "_alu_idle"}, {31'd0, bus.alu_ena, bus.alu_a}, {32'd0, bus.alu_b});
            end
            pop = bus.res_valid && bus.res_ready;
            if (pop && popped < vle) begin
                chk($sformatf("%s_data%0d", pfx, popped), 64'(bus.res_data), 64'(expq[popped]));
                chk($sformatf("%s_last%0d", pfx, popped), 64'(bus.res_last), 64'(popped == vle - 1));
            end
            hold   = bus.res_valid && !bus.res_ready;
            hold_d = bus.res_data;
            hold_l = bus.res_last;
            if (fire) begin
                fed++;
                fired++;
            end
            if (pop) begin
                popped++;
                if (popped == vle) pend_done = 1'b1;
            end
        end
        if (!seen_done) chk({pfx, "_done_timeout"}, 64'(seen_done), 64'd1);
        bus.src_valid = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_sel   = '0;
        bus.cmd_vl    = '0;
        bus.src_valid = 1'b0;
        bus.src_a     = '0;
        bus.src_b     = '0;
`ifdef VSEQ_MASK_EN
        bus.src_mask  = 1'b1;
`endif
        bus.res_ready = 1'b0;
        for (int i = 0; i < 64; i++) op_m[i] = 1'b1;

        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Add, vl=4
        op_a[0] = 1; op_a[1] = 2; op_a[2] = 3; op_a[3] = 4;
        for (int i = 0; i < 4; i++) op_b[i] = 10;
        run_cmd(VOP_ADD, 4, 0, 0, -1);

        // Sub then mul, vl=2
        op_a[0] = 5; op_a[1] = 0; op_b[0] = 7; op_b[1] = 1;
        run_cmd(VOP_SUB, 2, 0, 0, -1);
        op_a[0] = 32'h10000; op_a[1] = 3; op_b[0] = 32'h10000; op_b[1] = 4;
        run_cmd(VOP_MUL, 2, 0, 0, -1);

        // Backpressure
        fill_rand(3);
        run_cmd(VOP_ADD, 3, 2, 0, -1);

        // Zero length and clamped length
        run_cmd(VOP_ADD, 0, 0, 0, -1);
        fill_rand(64);
        run_cmd(VOP_SUB, 40, 1, 1, -1);

        // Constant and out-of-range opcodes
        fill_rand(2);
        run_cmd(VOP_CONST, 2, 0, 0, -1);
        run_cmd(3'd6, 2, 1, 1, -1);

        // Reset mid-command
        fill_rand(5);
        run_cmd(VOP_ADD, 5, 0, 0, 2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        bus.src_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("abort_after_done", {62'd0, bus.done, bus.res_valid}, 64'd0);
        end
        op_a[0] = 2; op_b[0] = 2;
        run_cmd(VOP_ADD, 1, 0, 0, -1);

`ifdef VSEQ_MASK_EN
        op_a[0] = 1; op_a[1] = 9; op_b[0] = 1; op_b[1] = 1;
        op_m[0] = 1'b1; op_m[1] = 1'b0;
        run_cmd(VOP_ADD, 2, 0, 0, -1);
`endif

        // Random commands
        for (int k = 0; k < 20; k++) begin
            fill_rand(64);
`ifdef VSEQ_MASK_EN
            for (int i = 0; i < 64; i++) op_m[i] = ($urandom % 4) != 0;
`endif
            run_cmd(3'($urandom % 8), int'($urandom % 64), int'($urandom % 3), int'($urandom % 2), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
